// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder that streams packed words into instruction memory.
// Define ENC_CHECK_EN to build immediate/format range checking that drives the sticky err flag.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  input  logic                  last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  // Handshake: a bundle is consumed on a rising edge where in_valid and in_ready
  // are both 1; in_ready is registered and is 1 only in LOAD, and the source must
  // hold the bundle stable while in_valid=1 and in_ready=0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [ADDR_WIDTH-1:0] BASE     = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   FULL     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0]           NOP_WORD = 32'h0000_0013;

  state_t      state;
  logic        accept;
  logic        last_slot;
  logic [31:0] enc_word;

  function automatic logic [31:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  r_d,
    input logic [4:0]  r_s1,
    input logic [4:0]  r_s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    case (f)
      FMT_I:   w = {im[11:0], r_s1, f3, r_d, op};
      FMT_S:   w = {im[11:5], r_s2, r_s1, f3, im[4:0], op};
      FMT_B:   w = {im[12], im[10:5], r_s2, r_s1, f3, im[4:1], im[11], op};
      FMT_U:   w = {im[31:12], r_d, op};
      FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], r_d, op};
      FMT_R:   w = {f7, r_s2, r_s1, f3, r_d, op};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

`ifdef ENC_CHECK_EN
  logic viol;

  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  function automatic logic violation(input logic [2:0] f, input logic [31:0] im);
    logic v;
    case (f)
      FMT_I, FMT_S: v = !((&im[31:11]) || (~|im[31:11]));
      FMT_B:        v = !((&im[31:12]) || (~|im[31:12])) || im[0];
      FMT_J:        v = !((&im[31:20]) || (~|im[31:20])) || im[0];
      FMT_U:        v = |im[11:0];
      FMT_R:        v = 1'b0;
      default:      v = 1'b1;
    endcase
    return v;
  endfunction

  always_comb viol = violation(fmt, imm);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    enc_word  = encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
    accept    = in_valid & in_ready;
    last_slot = ((count + ONE) == FULL);
  end

  assign busy      = (state != IDLE) | mem_we;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
`ifdef ENC_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            count    <= '0;
            ovf      <= 1'b0;
`ifdef ENC_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE + count[ADDR_WIDTH-1:0];
            mem_wdata <= enc_word;
            count     <= count + ONE;
`ifdef ENC_CHECK_EN
            if (viol) err <= 1'b1;
`endif
            // Filling the last address ends the session exactly like last=1.
            if (last || last_slot) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              done     <= 1'b1;
              ovf      <= last_slot & ~last;
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder (4-bit address space, base 13 to exercise wrap).
module tb_instr_encoder;

  localparam int AW   = 4;
  localparam int BASE = 13;
  localparam int EW   = 1 + 1 + 1 + (AW + 1) + AW + 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW:0]   count;
  logic          err;
  logic [1:0]    state_dbg;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .ovf(ovf), .count(count), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int sess_cnt = 0;
  bit sess_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fld(input logic [31:0] x, input int lo, input int n);
    return (longint'(x) >> lo) & ((64'd1 << n) - 1);
  endfunction

  function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] r_d,
      input logic [4:0] r_s1, input logic [4:0] r_s2, input logic [31:0] im);
    longint w;
    longint o  = longint'(op);
    longint d  = longint'(r_d) * 128;
    longint t3 = longint'(f3) * 4096;
    longint a  = longint'(r_s1) * 32768;
    longint b  = longint'(r_s2) * (64'd1 << 20);
    case (f)
      3'd0: w = o + d + t3 + a + fld(im, 0, 12) * (64'd1 << 20);
      3'd1: w = o + fld(im, 0, 5) * 128 + t3 + a + b + fld(im, 5, 7) * (64'd1 << 25);
      3'd2: w = o + fld(im, 11, 1) * 128 + fld(im, 1, 4) * 256 + t3 + a + b
              + fld(im, 5, 6) * (64'd1 << 25) + fld(im, 12, 1) * (64'd1 << 31);
      3'd3: w = o + d + fld(im, 12, 20) * 4096;
      3'd4: w = o + d + fld(im, 12, 8) * 4096 + fld(im, 11, 1) * (64'd1 << 20)
              + fld(im, 1, 10) * (64'd1 << 21) + fld(im, 20, 1) * (64'd1 << 31);
      3'd5: w = o + d + t3 + a + b + longint'(f7) * (64'd1 << 25);
      default: w = 64'h13;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_viol(input logic [2:0] f, input logic [31:0] im);
`ifdef ENC_CHECK_EN
    longint s = longint'($signed(im));
    bit odd = (im % 2) != 0;
    case (f)
      3'd0, 3'd1: return (s < -2048) || (s > 2047);
      3'd2:       return (s < -4096) || (s > 4094) || odd;
      3'd4:       return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || odd;
      3'd3:       return (im % 4096) != 0;
      3'd5:       return 1'b0;
      default:    return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {1'b1, mem_addr, mem_wdata}, 0);
      end else begin
        e = exp_q.pop_front();
        check("wdata", mem_wdata, e[31:0]);
        check("addr", mem_addr, e[32 +: AW]);
        check("count", count, e[32+AW +: AW+1]);
        check("err", err, e[EW-3]);
        check("ovf", ovf, e[EW-2]);
        check("done", done, e[EW-1]);
        check("busy_on_write", busy, 1);
      end
    end else if (rst_n === 1'b1) begin
      check("done_without_write", done, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sess_cnt = 0;
    sess_err = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] r_d, input logic [4:0] r_s1,
      input logic [4:0] r_s2, input logic [31:0] im, input logic lst);
    int budget = 0;
    bit fin, ov;
    logic [AW-1:0] a;
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = r_d; rs1 = r_s1; rs2 = r_s2; imm = im; last = lst;
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      if (start) begin
        start = 1'b0;
        sess_cnt = 0;
        sess_err = 0;
      end
      budget++;
      if (budget > 40) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    sess_cnt++;
    fin = lst || (sess_cnt == (1 << AW));
    ov  = (sess_cnt == (1 << AW)) && !lst;
    sess_err = sess_err | ref_viol(f, im);
    a = AW'((BASE + sess_cnt - 1) % (1 << AW));
    exp_q.push_back({fin, ov, sess_err, (AW+1)'(sess_cnt), a,
                     ref_encode(f, op, f3, f7, r_d, r_s1, r_s2, im)});
    @(negedge clk);
  endtask

  task automatic send_rand(input logic lst);
    logic [31:0] im;
    if ($urandom_range(0, 3) == 0) im = $urandom;
    else im = 32'($signed($urandom_range(0, 8191)) - 4096);
    send(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
         5'($urandom), 5'($urandom), 5'($urandom), im, lst);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, BASE % (1 << AW));
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic check_idle_after(input int n_words, input bit exp_ovf);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_count", count, n_words);
    check("idle_ovf", ovf, exp_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // addi x1,x0,5
    do_start();
    send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    idle(2);
    check_idle_after(1, 0);

    // sw / beq / jal back-to-back
    do_start();
    send(3'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0);
    send(3'd4, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
    idle(2);
    check_idle_after(3, 0);

    // lui x5,0x12345000, then addi with an out-of-range immediate
    do_start();
    send(3'd3, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    idle(1);
    do_start();
    send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
    idle(2);
    do_start();
    check("err_cleared_by_start", err, 0);
    send(3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0, 1'b1);
    idle(2);

    // start together with in_valid in IDLE
    start = 1'b1;
    send(3'd0, 7'h13, 3'd0, 7'd0, 5'd7, 5'd7, 5'd0, 32'd1, 1'b1);
    idle(2);
    check_idle_after(1, 0);

    // exhaustion without last; the 17th bundle must stay unconsumed
    do_start();
    for (int i = 0; i < (1 << AW); i++) send_rand(1'b0);
    fmt = 3'd0; opcode = 7'h13; last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("exhaust_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_idle_after(1 << AW, 1);

    // exhaustion coinciding with last: no ovf
    do_start();
    check("ovf_cleared_by_start", ovf, 0);
    for (int i = 0; i < (1 << AW); i++) send_rand(i == (1 << AW) - 1);
    idle(2);
    check_idle_after(1 << AW, 0);

    // reset with a second bundle presented mid-session
    do_start();
    send_rand(1'b0);
    fmt = 3'd0; opcode = 7'h13; last = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_reset_vals("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst_rel");

    // randomized sessions with occasional gaps
    for (int s = 0; s < 30; s++) begin
      do_start();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        send_rand(i == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      check_idle_after(len, 0);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder and instruction-memory loader. It accepts field-level instruction descriptions over a valid/ready stream. Each one is packed into a 32-bit RV32I word and written sequentially into instruction memory through a single write port. It is the writer-side counterpart of the control-unit decode path, used by the boot/test loader to place programs before the core is released.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after `start`

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a load session; ignored while busy
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 illegal
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25] (R only)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  sign-extended immediate (U: full upper value)
- last  in  1  bundle is final instruction of session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session active or write pending
- done  out  1  one-cycle pulse, session ended
- ovf  out  1  session ended by address-space exhaustion
- count  out  ADDR_WIDTH+1  words written this session
- err  out  1  sticky encoding violation (see Configuration)

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE: in_ready=0. When start=1, go to LOAD, count<=0, ovf<=0, err<=0.
- LOAD: in_ready=1. A bundle is accepted when in_valid&in_ready. The encoded word is registered. If last=1 or count+1 == 2^ADDR_WIDTH, go to DRAIN; otherwise stay in LOAD.
- DRAIN: in_ready=0. The final write issues, done=1 this cycle, and the FSM returns to IDLE. ovf=1 if the session ended by exhaustion without last; ovf holds until the next start.
- Write: one cycle after accept, mem_we=1, mem_addr=BASE_ADDR+count (mod 2^ADDR_WIDTH), mem_wdata=encoded word. count increments in the same cycle.
- Packing:
  - I: imm[11:0],rs1,f3,rd,op
  - S: imm[11:5],rs2,rs1,f3,imm[4:0],op
  - B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op
  - U: imm[31:12],rd,op
  - J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op
  - R: f7,rs2,rs1,f3,rd,op
  - illegal fmt: 0x00000013 (NOP)
- Unused input bits are ignored, with immediate bits truncated per format.
- busy = (state != IDLE) | mem_we.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, ovf=0, count=0, err=0, state IDLE.
- Latency: accept to mem_we is 1 cycle. Throughput is 1 word/cycle in LOAD.
- done is asserted in the same cycle as the final mem_we.
- start together with in_valid in IDLE: only start takes effect; the bundle is not accepted until the next cycle.
- in_valid while in_ready=0: the bundle is held by the source and not consumed.
- Reset mid-session: the pending write is dropped (mem_we=0 in the cycle after rst_n low) and all state returns to reset values.
- Exhaustion: the accept that fills the last address behaves like last=1 and sets ovf. Addresses wrap modulo 2^ADDR_WIDTH from BASE_ADDR, so a session never writes an address twice.

## Configuration
- ENC_CHECK_EN defined:
  - Each accepted bundle is checked.
    - I/S: imm in [-2048, 2047]
    - B: imm in [-4096, 4094] and even
    - J: imm in [-2^20, 2^20-2] and even
    - U: imm[11:0]==0
    - fmt must be legal
  - A violation sets err (sticky until start or reset) in the write cycle. The word is still written, truncated or NOP.
- ENC_CHECK_EN undefined: err is tied to 0 and no checking logic is built.

## Test plan
- addi x1,x0,5 (fmt I, op 0x13, f3 0, imm 5), last=1 -> mem_we at addr 0, wdata 0x00500093, done pulse same cycle, count=1.
- Stream of three back-to-back bundles -> consecutive words at addrs 0,1,2:
  - sw x2,8(x1) (S, op 0x23, f3 2) -> 0x0020A423
  - beq x0,x0,-4 (B, op 0x63) -> 0xFE000EE3
  - jal x1,8 (J, op 0x6F), last=1 -> 0x008000EF
- lui x5,0x12345000 (U, op 0x37), BASE_ADDR=16 -> addr 16, wdata 0x123452B7.
- ADDR_WIDTH=2, five bundles without last -> four writes (addrs 0..3), done and ovf=1 on the 4th, in_ready=0 after; the fifth bundle is not consumed.
- rst_n low in the cycle after an accept -> no mem_we, all outputs at reset values; a new start works normally.
- ENC_CHECK_EN defined, addi with imm 4096 -> err=1, wdata 0x00000093. The next start clears err. With the macro undefined, err stays 0.
